// File: rtl/tas_serial_tx_if.sv
// Byte-queue handshake plus serial link signals of the tas transmitter.
// master = byte source / link consumer side, slave = transmitter side.
interface tas_serial_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       hold;
    logic       serial_data;
    logic       data_ena;
    logic       byte_done;

    modport master (
        output tx_data, tx_valid, hold,
        input  tx_ready, serial_data, data_ena, byte_done
    );

    modport slave (
        input  tx_data, tx_valid, hold,
        output tx_ready, serial_data, data_ena, byte_done
    );
endinterface

// File: rtl/tas_serial_tx.sv
// tas serial transmitter: byte FIFO feeding an LSB-first shifter framed by data_ena,
// with a fixed inter-byte gap and a hold input that defers byte starts.
module tas_serial_tx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk_50,
    input  logic                        reset,
    tas_serial_tx_if.slave              link,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]            sent_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             serial_q, serial_d;
    logic             ena_q, ena_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             push_c, pop_c, start_c, load_c;

    assign push_c  = link.tx_valid && ready_q;
    assign start_c = (count_q != '0) && !link.hold;

    // Next-state and registered-output logic; a byte load is shared by IDLE and the last GAP cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sent_d    = sent_q;
        serial_d  = 1'b0;
        ena_d     = 1'b0;
        done_d    = 1'b0;
        load_c    = 1'b0;
        pop_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                load_c = start_c;
            end
            SHIFT: begin
                if (bit_cnt_q == 3'd7) begin
                    done_d    = 1'b1;
                    sent_d    = sent_q + CNT_W'(1);
                    gap_cnt_d = GW'(GAP_CYCLES - 1);
                    state_d   = GAP;
                end else begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    serial_d  = shift_q[1];
                    ena_d     = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end else if (start_c) begin
                    load_c = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_c) begin
            pop_c     = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            serial_d  = mem_q[rd_ptr_q][0];
            ena_d     = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = SHIFT;
        end

        count_d = count_q + CW'(push_c) - CW'(pop_c);
        ready_d = (count_d != CW'(FIFO_DEPTH));
        busy_d  = (state_d != IDLE) || (count_d != '0);
    end

    // State, pointers and output registers.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sent_q    <= '0;
            serial_q  <= 1'b0;
            ena_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sent_q    <= sent_d;
            serial_q  <= serial_d;
            ena_q     <= ena_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_50) begin
        if (push_c) mem_q[wr_ptr_q] <= link.tx_data;
    end

    assign link.tx_ready    = ready_q;
    assign link.serial_data = serial_q;
    assign link.data_ena    = ena_q;
    assign link.byte_done   = done_q;
    assign busy             = busy_q;
    assign fifo_count       = count_q;
    assign sent_count       = sent_q;

endmodule

// File: tb/tb_tas_serial_tx.sv
// Directed and random checks of tas_serial_tx; instance 0 uses a 1-cycle gap, instance 1 a 3-cycle gap.
module tb_tas_serial_tx;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]       txd [2];
    logic             txv [2];
    logic             hld [2];
    logic             rdy_w [2];
    logic             ser_w [2];
    logic             ena_w [2];
    logic             bd_w [2];
    logic             busy_w [2];
    logic [CW-1:0]    fc_w [2];
    logic [CNT_W-1:0] sc_w [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tas_serial_tx_if link ();
        assign link.tx_data  = txd[g];
        assign link.tx_valid = txv[g];
        assign link.hold     = hld[g];
        assign rdy_w[g]      = link.tx_ready;
        assign ser_w[g]      = link.serial_data;
        assign ena_w[g]      = link.data_ena;
        assign bd_w[g]       = link.byte_done;

        tas_serial_tx #(
            .FIFO_DEPTH (DEPTH),
            .GAP_CYCLES ((g == 0) ? 1 : 3),
            .CNT_W      (CNT_W)
        ) u_dut (
            .clk_50     (clk),
            .reset      (rst),
            .link       (link.slave),
            .busy       (busy_w[g]),
            .fifo_count (fc_w[g]),
            .sent_count (sc_w[g])
        );
    end

    // Link monitor: decodes framed bytes and records data_ena edges per instance.
    logic [7:0] rxb [2][256];
    int         rise [2][256];
    int         fall [2][256];
    int         nrx [2], nrise [2], nfall [2];
    int         ser_bad [2], bd_bad [2], run_bad [2], rl [2];
    logic [7:0] sh [2];
    bit         prev [2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                rl[g]   = 0;
                prev[g] = 1'b0;
            end else begin
                if (ser_w[g] && !ena_w[g]) ser_bad[g]++;
                if (bd_w[g] !== (prev[g] && !ena_w[g])) bd_bad[g]++;
                if (ena_w[g]) begin
                    if (!prev[g]) begin
                        rise[g][nrise[g] & 255] = cyc;
                        nrise[g]++;
                    end
                    sh[g] = {ser_w[g], sh[g][7:1]};
                    rl[g]++;
                    if (rl[g] == 8) begin
                        rxb[g][nrx[g] & 255] = sh[g];
                        nrx[g]++;
                    end
                end else begin
                    if (prev[g]) begin
                        fall[g][nfall[g] & 255] = cyc;
                        nfall[g]++;
                        if (rl[g] != 8) run_bad[g]++;
                    end
                    rl[g] = 0;
                end
                prev[g] = ena_w[g];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int g, input logic [7:0] b);
        txd[g] = b;
        txv[g] = 1'b1;
        tick();
        txv[g] = 1'b0;
    endtask

    task automatic wait_rx(input int g, input int target, input int budget, input string tag);
        int n = 0;
        while (nrx[g] < target && n < budget) begin
            tick();
            n++;
        end
        check({tag, " rx wait"}, 32'(nrx[g] >= target), 32'd1);
    endtask

    task automatic wait_idle(input int g, input int budget, input string tag);
        int n = 0;
        while (busy_w[g] !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, " busy idle"}, 32'(busy_w[g]), 32'd0);
    endtask

    int         exp_sent [2];
    int         base, rb, fb, np, n;
    logic [7:0] b;
    logic [7:0] exp_q [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            txd[g] = 8'h00;
            txv[g] = 1'b0;
            hld[g] = 1'b0;
            exp_sent[g] = 0;
        end
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            check("rst data_ena", 32'(ena_w[g]), 32'd0);
            check("rst serial", 32'(ser_w[g]), 32'd0);
            check("rst byte_done", 32'(bd_w[g]), 32'd0);
            check("rst busy", 32'(busy_w[g]), 32'd0);
            check("rst fifo_count", 32'(fc_w[g]), 32'd0);
            check("rst sent_count", 32'(sc_w[g]), 32'd0);
            check("rst tx_ready", 32'(rdy_w[g]), 32'd1);
        end
        rst = 1'b0;
        repeat (2) tick();

        // single byte: latency and bit order
        base = nrx[0];
        b = 8'hA5;
        push(0, b);
        check("t1 pre-start ena", 32'(ena_w[0]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1 ena", 32'(ena_w[0]), 32'd1);
            check("t1 bit", 32'(ser_w[0]), 32'(b[i]));
        end
        tick();
        check("t1 end ena", 32'(ena_w[0]), 32'd0);
        check("t1 byte_done", 32'(bd_w[0]), 32'd1);
        exp_sent[0] += 1;
        check("t1 sent", 32'(sc_w[0]), 32'(exp_sent[0]));
        wait_idle(0, 20, "t1");
        check("t1 rx byte", 32'(rxb[0][base & 255]), 32'hA5);

        // held burst of five
        exp_q = '{8'hA5, 8'h0A, 8'h14, 8'h1E, 8'h28};
        hld[0] = 1'b1;
        base = nrx[0]; rb = nrise[0]; fb = nfall[0];
        foreach (exp_q[i]) push(0, exp_q[i]);
        check("t2 fifo_count", 32'(fc_w[0]), 32'd5);
        repeat (3) tick();
        check("t2 held ena", 32'(ena_w[0]), 32'd0);
        check("t2 held busy", 32'(busy_w[0]), 32'd1);
        hld[0] = 1'b0;
        wait_rx(0, base + 5, 100, "t2");
        repeat (2) tick();
        foreach (exp_q[i]) check("t2 rx byte", 32'(rxb[0][(base + i) & 255]), 32'(exp_q[i]));
        check("t2 burst span", 32'(fall[0][(fb + 4) & 255] - rise[0][rb & 255]), 32'd44);
        for (int i = 1; i < 5; i++)
            check("t2 gap", 32'(rise[0][(rb + i) & 255] - fall[0][(fb + i - 1) & 255]), 32'd1);
        exp_sent[0] += 5;
        check("t2 sent", 32'(sc_w[0]), 32'(exp_sent[0]));
        check("t2 fifo empty", 32'(fc_w[0]), 32'd0);

        // three-cycle gap instance
        base = nrx[1]; rb = nrise[1]; fb = nfall[1];
        txd[1] = 8'h3C; txv[1] = 1'b1;
        tick();
        txd[1] = 8'h43;
        tick();
        txv[1] = 1'b0;
        wait_rx(1, base + 2, 100, "t3");
        repeat (2) tick();
        check("t3 rx byte0", 32'(rxb[1][base & 255]), 32'h3C);
        check("t3 rx byte1", 32'(rxb[1][(base + 1) & 255]), 32'h43);
        check("t3 gap", 32'(rise[1][(rb + 1) & 255] - fall[1][fb & 255]), 32'd3);
        check("t3 serial in gap", 32'(ser_bad[1]), 32'd0);
        check("t3 run length", 32'(run_bad[1]), 32'd0);
        check("t3 byte_done", 32'(bd_bad[1]), 32'd0);
        check("t3 sent", 32'(sc_w[1]), 32'd2);

        // fill to full, overflow attempt, refill after first pop
        hld[0] = 1'b1;
        base = nrx[0];
        exp_q = {};
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push(0, b);
        end
        check("t4 full ready", 32'(rdy_w[0]), 32'd0);
        check("t4 full count", 32'(fc_w[0]), 32'd16);
        push(0, 8'hEE);
        check("t4 overflow count", 32'(fc_w[0]), 32'd16);
        txd[0] = 8'h99; txv[0] = 1'b1; hld[0] = 1'b0;
        n = 0;
        while (rdy_w[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t4 ready after pop", 32'(rdy_w[0]), 32'd1);
        tick();
        txv[0] = 1'b0;
        check("t4 refill count", 32'(fc_w[0]), 32'd16);
        exp_q.push_back(8'h99);
        wait_rx(0, base + 17, 250, "t4");
        foreach (exp_q[i]) check("t4 rx byte", 32'(rxb[0][(base + i) & 255]), 32'(exp_q[i]));
        exp_sent[0] += 17;
        repeat (3) tick();
        check("t4 sent", 32'(sc_w[0]), 32'(exp_sent[0]));

        // hold asserted mid-byte
        base = nrx[0];
        b = 8'hC3;
        push(0, b);
        push(0, 8'h55);
        repeat (3) tick();
        check("t5 bit3 ena", 32'(ena_w[0]), 32'd1);
        check("t5 bit3", 32'(ser_w[0]), 32'(b[3]));
        hld[0] = 1'b1;
        wait_rx(0, base + 1, 20, "t5");
        check("t5 C3 complete", 32'(rxb[0][base & 255]), 32'hC3);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5 held ena", 32'(ena_w[0]), 32'd0);
        end
        check("t5 held count", 32'(fc_w[0]), 32'd1);
        hld[0] = 1'b0;
        tick();
        check("t5 start ena", 32'(ena_w[0]), 32'd1);
        check("t5 start bit0", 32'(ser_w[0]), 32'd1);
        wait_rx(0, base + 2, 20, "t5b");
        check("t5 rx 55", 32'(rxb[0][(base + 1) & 255]), 32'h55);
        exp_sent[0] += 2;
        repeat (3) tick();
        check("t5 sent", 32'(sc_w[0]), 32'(exp_sent[0]));

        // random pushes with random hold; at most 15 outstanding so every push fits
        base = nrx[0];
        np = 0;
        exp_q = {};
        for (int c = 0; c < 80; c++) begin
            hld[0] = ($urandom_range(3) == 0);
            if (np < 15 && $urandom_range(4) == 0) begin
                b = 8'($urandom);
                txd[0] = b;
                txv[0] = 1'b1;
                check("rand ready", 32'(rdy_w[0]), 32'd1);
                exp_q.push_back(b);
                np++;
            end else begin
                txv[0] = 1'b0;
            end
            tick();
        end
        txv[0] = 1'b0;
        hld[0] = 1'b0;
        wait_rx(0, base + np, 300, "rand");
        foreach (exp_q[i]) check("rand rx byte", 32'(rxb[0][(base + i) & 255]), 32'(exp_q[i]));
        exp_sent[0] += np;
        repeat (3) tick();
        check("rand sent", 32'(sc_w[0]), 32'(exp_sent[0]));
        check("rand serial idle", 32'(ser_bad[0]), 32'd0);
        check("rand run length", 32'(run_bad[0]), 32'd0);
        check("rand byte_done", 32'(bd_bad[0]), 32'd0);

        // reset mid-byte
        hld[0] = 1'b1;
        push(0, 8'h7F);
        push(0, 8'h11);
        push(0, 8'h22);
        hld[0] = 1'b0;
        tick();
        repeat (4) tick();
        check("t6 bit4 ena", 32'(ena_w[0]), 32'd1);
        check("t6 bit4", 32'(ser_w[0]), 32'd1);
        rb = nrise[0];
        rst = 1'b1;
        #1;
        check("t6 rst ena", 32'(ena_w[0]), 32'd0);
        check("t6 rst serial", 32'(ser_w[0]), 32'd0);
        check("t6 rst count", 32'(fc_w[0]), 32'd0);
        check("t6 rst sent", 32'(sc_w[0]), 32'd0);
        check("t6 rst ready", 32'(rdy_w[0]), 32'd1);
        check("t6 rst busy", 32'(busy_w[0]), 32'd0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("t6 no restart", 32'(nrise[0]), 32'(rb));
        check("t6 post count", 32'(fc_w[0]), 32'd0);
        check("t6 post sent", 32'(sc_w[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tas_serial_tx.md
Name: tas_serial_tx

Overview:
- Transmit end of the tas serial byte link: queues parallel bytes and serializes them LSB-first onto serial_data, framing each byte with data_ena in the 50 MHz domain.
- Acts as the packet source feeding tas: header byte (A5/C3 temperature, others non-temperature) followed by four data bytes.
- Buffers bytes while the link is unavailable ("dark side", hold high) and bursts them at maximum rate once hold drops.
- Packet content is opaque to this block; it moves bytes only.

Parameters:
- FIFO_DEPTH, 16, byte FIFO entries; power of two, at least 2.
- GAP_CYCLES, 1, data_ena-low cycles inserted between consecutive bytes; at least 1.
- CNT_W, 16, width of sent_count.

Ports:
- clk_50  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to queue.
- tx_valid  in  1  tx_data valid; byte is accepted on an edge where tx_valid and tx_ready are both high.
- tx_ready  out  1  FIFO not full.
- hold  in  1  high blocks the start of new bytes; a byte already in progress completes.
- serial_data  out  1  serial bit, LSB first; 0 whenever data_ena is low.
- data_ena  out  1  high for exactly 8 consecutive cycles per byte.
- byte_done  out  1  one-cycle pulse in the first cycle after a byte's bit 7.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- sent_count  out  CNT_W  count of completed bytes; wraps from all-ones to 0.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, immediate):
  - serial_data=0, data_ena=0, byte_done=0, busy=0, fifo_count=0, sent_count=0, tx_ready=1.
  - FIFO is flushed, FSM goes to IDLE.
  - Reset mid-byte truncates the byte; there is no resume. Reset deassertion is synchronous to clk_50 in the caller.
- FIFO:
  - Synchronous; read and write pointers wrap modulo FIFO_DEPTH.
  - Push and pop on the same edge are allowed; occupancy is unchanged.
  - tx_ready = (fifo_count != FIFO_DEPTH). A push while full is not accepted, and tx_data is ignored.
  - A pop from an empty FIFO cannot occur, because the FSM pops only when the FIFO is non-empty.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if the FIFO is non-empty and hold=0 at an edge, pop the head into an 8-bit shift register. At that same edge, drive data_ena=1 and serial_data=bit0, set bit_cnt=0, and go to SHIFT. Otherwise outputs stay low.
  - SHIFT: each edge, shift right and increment bit_cnt. Bits 1..7 appear on successive cycles.
  - SHIFT exit: at the edge where bit_cnt==7, drive data_ena=0 and serial_data=0, pulse byte_done=1, increment sent_count, load gap_cnt=GAP_CYCLES-1, and go to GAP.
  - GAP: while gap_cnt!=0, decrement it.
  - GAP exit: at the edge where gap_cnt==0, apply the IDLE start condition directly. Next byte present with hold=0 loads immediately; otherwise go to IDLE.
- Resulting timing:
  - Latency: a byte accepted at edge k into an empty FIFO, with the FSM in IDLE and hold=0, drives its bit0 from edge k+1.
  - Back-to-back bytes have exactly GAP_CYCLES low cycles between them.
  - A continuous burst of N bytes occupies 8N + GAP_CYCLES*(N-1) cycles, from the first data_ena rise to the last data_ena fall.
- Hold:
  - Sampled only at byte-start decision edges (IDLE, or the final GAP cycle).
  - Asserting hold during SHIFT or GAP does not truncate the byte or shorten the gap.
  - Pushes continue while hold is high.
- busy is the registered form of (state != IDLE) || (FIFO non-empty).
- sent_count increments only on byte completion, never on push or pop.

Test Plan:
1. Reset release, then push A5 with hold=0 -> from the next edge, serial_data = 1,0,1,0,0,1,0,1 with data_ena high for 8 cycles; byte_done pulses once; sent_count=1; busy returns to 0.
2. hold=1, push A5,0A,14,1E,28; fifo_count=5; release hold -> 5 bytes with one low cycle between each; 44 cycles from first data_ena rise to last fall; sent_count=5; fifo_count=0.
3. GAP_CYCLES=3, push 3C then 43 back-to-back -> exactly 3 data_ena-low cycles between the two bytes; serial_data is 0 during the gap.
4. hold=1, attempt 17 pushes with FIFO_DEPTH=16 -> tx_ready low after the 16th accept; 17th byte not accepted; fifo_count=16; release hold -> 16 bytes sent in order; the first push after the first pop is accepted.
5. Assert hold at bit 3 of byte C3 while 55 is queued -> C3 completes all 8 bits; 55 is not started until hold drops; then 55 starts on the first edge with hold=0.
6. Assert reset at bit 4 of 7F with 2 bytes queued -> data_ena and serial_data go to 0 immediately; fifo_count=0; sent_count=0; no further data_ena after reset release.
